mod53_mul_seq: RTL
==================

MOD53_MUL_SEQ -- requirements
Module: mod53_mul_seq

Interface
REQ-001 Parameter MOD, default 53, modulus; all legal residues lie in 0..MOD-1.
REQ-002 Parameter W, default 6, residue width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair a/b present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  W  multiplicand residue.
REQ-008 b  input  W  multiplier residue.
REQ-009 out_valid  output  1  result z/out_err present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 z  output  W  result (a*b) mod MOD.
REQ-012 out_err  output  1  accepted operand was out of range (>= MOD).

Function
REQ-013 The block SHALL sequence a shared combinational modular adder to compute (a*b) mod MOD MSB-first: acc=0; for i=W-1 down to 0, acc=(acc+acc) mod MOD, then if b[i], acc=(acc+a) mod MOD.
REQ-014 The block SHALL process exactly one multiplier bit per BUSY cycle, performing double and conditional add in the same cycle through two adder instances.
REQ-015 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs at an edge where in_valid and in_ready are both 1.
REQ-017 On transfer with a<MOD and b<MOD, the block SHALL latch a and b, clear acc, load bit counter = W-1, and enter BUSY.
REQ-018 On transfer with a>=MOD or b>=MOD, the block SHALL enter DONE at that edge with z=0 and out_err=1, skipping BUSY.
REQ-019 BUSY SHALL last exactly W edges; at the edge that processes bit 0 the block SHALL enter DONE, so out_valid rises W edges after the accepting edge (6 for the defaults).
REQ-020 In DONE, out_valid=1 and z/out_err SHALL stay stable until an edge with out_ready=1, after which the block SHALL return to IDLE.
REQ-021 in_ready SHALL stay 0 in the cycle the result is consumed; the next operand is accepted no earlier than the following edge.
REQ-022 in_valid, a and b SHALL be ignored outside IDLE, and changing them during BUSY SHALL not affect the result.
REQ-023 Each adder SHALL compute s=x+y in W+1 bits and subtract MOD when s>=MOD; with operands <MOD the result is always <MOD.
REQ-024 z SHALL be driven from a register, not from the adder outputs.

Reset
REQ-025 When rst_n=0, asynchronously: state=IDLE, acc=0, latched operands=0, counter=0, z=0, out_err=0, out_valid=0, in_ready=0.
REQ-026 in_ready SHALL become 1 from the first cycle after rst_n deasserts.
REQ-027 Reset asserted during BUSY or DONE SHALL abort the operation with no result emitted; the first operation after reset SHALL be correct.

Structure
REQ-028 MOD, W and the FSM state encoding SHALL live in the shared package mod53_pkg.
REQ-029 The combinational modular adder SHALL be the sub-module mod53_add (ports x, y, s, all W bits), instantiated twice: once for doubling, once for the conditional add.

Verification
REQ-030 The bench SHALL cover a=7, b=8 -> z=3, out_err=0, with out_valid 6 edges after acceptance.
REQ-031 The bench SHALL cover a=52, b=52 -> z=1; and a=10, b=10 -> z=47.
REQ-032 The bench SHALL cover a=0, b=37 -> z=0; and a=2, b=27 -> z=1, which exercises the wrap at 54.
REQ-033 The bench SHALL cover a=53, b=5 -> out_valid at the edge after acceptance, z=0, out_err=1.
REQ-034 The bench SHALL cover back-pressure: out_ready=0 for 10 cycles -> z and out_valid held, in_ready=0 throughout, and the result is consumed on the first out_ready=1.
REQ-035 The bench SHALL cover rst_n pulsed low in the 3rd BUSY cycle -> all outputs 0 at once, no out_valid, then a=3, b=18 -> z=1; it SHALL also compare all 53x53 operand pairs against a reference model.

Source files
------------

// File: rtl/mod53_pkg.sv
// Shared constants and FSM encoding for the sequential mod-53 multiplier.
package mod53_pkg;

    // Default modulus and residue width
    localparam int MOD = 53;
    localparam int W   = 6;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod53_add.sv
// Combinational modular adder: s = (x + y) mod MOD for x, y < MOD.
module mod53_add #(
    parameter int MOD = mod53_pkg::MOD,
    parameter int W   = mod53_pkg::W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s
);

    localparam logic [W:0] MOD_EXT = (W+1)'(MOD);

    logic [W:0] sum;
    logic [W:0] red;

    // One conditional subtract suffices because x + y < 2*MOD
    always_comb begin
        sum = {1'b0, x} + {1'b0, y};
        red = sum - MOD_EXT;
        s   = (sum >= MOD_EXT) ? red[W-1:0] : sum[W-1:0];
    end

endmodule

// File: rtl/mod53_mul_seq.sv
// Sequential modular multiplier: z = (a*b) mod MOD, one multiplier bit per
// cycle MSB-first (double then conditional add), with valid/ready handshakes.
module mod53_mul_seq #(
    parameter int MOD = mod53_pkg::MOD,
    parameter int W   = mod53_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         out_err
);

    import mod53_pkg::*;

    localparam int             CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [W:0]     MOD_EXT = (W+1)'(MOD);
    localparam logic [CW-1:0]  CNT_TOP = CW'(W-1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   z_q, z_d;
    logic           err_q, err_d;
    logic           vld_q, vld_d;
    logic           rdy_q, rdy_d;

    logic           take;
    logic           op_bad;
    logic [W-1:0]   dbl;
    logic [W-1:0]   dbl_plus_a;

    // Doubling and conditional-add share the same cycle, so two adders
    mod53_add #(.MOD(MOD), .W(W)) u_dbl (
        .x (acc_q),
        .y (acc_q),
        .s (dbl)
    );

    mod53_add #(.MOD(MOD), .W(W)) u_add (
        .x (dbl),
        .y (a_q),
        .s (dbl_plus_a)
    );

    assign take      = in_valid & rdy_q;
    assign op_bad    = ({1'b0, a} >= MOD_EXT) | ({1'b0, b} >= MOD_EXT);
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign z         = z_q;
    assign out_err   = err_q;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state: bad operands skip straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (take) state_d = op_bad ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; in_ready is registered so it stays
    // low in the consume cycle and through reset
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        z_d   = z_q;
        err_d = err_q;
        vld_d = vld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (op_bad) begin
                        z_d   = '0;
                        err_d = 1'b1;
                        vld_d = 1'b1;
                    end else begin
                        a_d   = a;
                        b_d   = b;
                        acc_d = '0;
                        cnt_d = CNT_TOP;
                        err_d = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                acc_d = b_q[cnt_q] ? dbl_plus_a : dbl;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    z_d   = acc_d;
                    err_d = 1'b0;
                    vld_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) vld_d = 1'b0;
            end
            default: ;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

endmodule
